// File: rtl/bldc_gate_drive.sv
`default_nettype none
// ============================================================================
// Module   : bldc_gate_drive
// Purpose  : Converts the 6-bit phase status word {AH,AL,BH,BL,CH,CL} into
//            the six H-bridge gate signals. High-side switches are chopped by
//            an edge-aligned PWM, and low-side switches are held on. Each
//            commutation inserts a programmable all-off dead time. Illegal
//            shoot-through requests latch a sticky fault.
// Ports    : clk_i, rst_ni (async, active-low)
//            ena_i        - enable; low forces IDLE and clears the fault
//            status_i     - requested phase pattern
//            period_i     - PWM counter top (period minus 1)
//            duty_i       - high-side on-cycles per period
//            deadtime_i   - all-off cycles per commutation
//            gate_o       - registered gate drive, same bit order as status_i
//            pwm_sync_o   - registered pulse on the PWM period-start cycle
//            fault_o      - registered sticky shoot-through fault
// Revision : 1.0 - initial release
// ============================================================================
module bldc_gate_drive #(
  parameter int CNT_W = 10,
  parameter int DT_W  = 6
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             ena_i,
  input  logic [5:0]       status_i,
  input  logic [CNT_W-1:0] period_i,
  input  logic [CNT_W-1:0] duty_i,
  input  logic [DT_W-1:0]  deadtime_i,
  output logic [5:0]       gate_o,
  output logic             pwm_sync_o,
  output logic             fault_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DEAD  = 2'd2,
    S_FAULT = 2'd3
  } state_e;

  // Low-side bits stay on while the high-side bits are in their PWM off-phase.
  localparam logic [5:0] c_LS_MASK = 6'b010101;

  state_e           state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] duty_q,   duty_d;
  logic [5:0]       status_q, status_d;
  logic [DT_W-1:0]  dt_q,     dt_d;
  logic [5:0]       gate_q,   gate_d;
  logic             sync_q,   sync_d;
  logic             fault_q,  fault_d;

  logic             w_illegal;
  logic             w_pwm_on;

  assign w_illegal = (status_i[5] & status_i[4]) |
                     (status_i[3] & status_i[2]) |
                     (status_i[1] & status_i[0]);

  // Next-state logic. Priority: ena_i low, illegal pattern, commutation,
  // then PWM wrap.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    duty_d   = duty_q;
    status_d = status_q;
    dt_d     = dt_q;

    if (!ena_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          period_d = period_i;
          duty_d   = duty_i;
          status_d = status_i;
          cnt_d    = '0;
          state_d  = S_RUN;
        end
        S_RUN, S_DEAD: begin
          if (w_illegal) begin
            state_d = S_FAULT;
            cnt_d   = '0;
          end else begin
            // PWM counter keeps running through dead time; period and duty
            // are shadow-loaded only at the wrap to avoid mid-period glitches.
            if (cnt_q == period_q) begin
              cnt_d    = '0;
              period_d = period_i;
              duty_d   = duty_i;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end

            if (state_q == S_RUN) begin
              if (status_i != status_q) begin
                if (deadtime_i == '0) begin
                  status_d = status_i;
                end else begin
                  dt_d    = deadtime_i;
                  state_d = S_DEAD;
                end
              end
            end else begin
              // The pending target is simply the live request: the latest
              // status_i wins and the dead-time count is never restarted.
              dt_d = dt_q - DT_W'(1);
              if (dt_q <= DT_W'(1)) begin
                status_d = status_i;
                state_d  = S_RUN;
              end
            end
          end
        end
        S_FAULT: begin
          cnt_d = '0;
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are derived from the next-state values so they line up with the
  // edge that commits the state.
  assign w_pwm_on = (cnt_d < duty_d);

  always_comb begin
    gate_d  = '0;
    sync_d  = 1'b0;
    fault_d = 1'b0;
    case (state_d)
      S_RUN: begin
        gate_d = w_pwm_on ? status_d : (status_d & c_LS_MASK);
        sync_d = (cnt_d == '0);
      end
      S_DEAD: begin
        sync_d = (cnt_d == '0);
      end
      S_FAULT: begin
        fault_d = 1'b1;
      end
      default: begin
        gate_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      duty_q   <= '0;
      status_q <= '0;
      dt_q     <= '0;
      gate_q   <= '0;
      sync_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      duty_q   <= duty_d;
      status_q <= status_d;
      dt_q     <= dt_d;
      gate_q   <= gate_d;
      sync_q   <= sync_d;
      fault_q  <= fault_d;
    end
  end

  assign gate_o     = gate_q;
  assign pwm_sync_o = sync_q;
  assign fault_o    = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_bldc_gate_drive.sv
`default_nettype none
// ============================================================================
// Module   : tb_bldc_gate_drive
// Purpose  : Self-checking bench for bldc_gate_drive. A stimulus process
//            drives directed and random inputs and pushes the response of a
//            behavioural model into a queue; a monitor pops and compares the
//            registered outputs every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bldc_gate_drive;

  localparam int CNT_W = 10;
  localparam int DT_W  = 6;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             ena;
  logic [5:0]       status;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] duty;
  logic [DT_W-1:0]  dt;
  logic [5:0]       gate_o;
  logic             pwm_sync_o;
  logic             fault_o;

  bldc_gate_drive #(.CNT_W(CNT_W), .DT_W(DT_W)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .ena_i      (ena),
    .status_i   (status),
    .period_i   (period),
    .duty_i     (duty),
    .deadtime_i (dt),
    .gate_o     (gate_o),
    .pwm_sync_o (pwm_sync_o),
    .fault_o    (fault_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] g;
    logic       s;
    logic       f;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Behavioural model: "active" means the bridge is being driven, "faulted"
  // latches a shoot-through request, dead_left counts remaining all-off cycles,
  // phase is the position within the PWM period.
  bit         m_active, m_faulted;
  int         m_phase, m_per, m_duty, m_dead_left;
  logic [5:0] m_pat;

  function automatic bit is_illegal(logic [5:0] s);
    return (s[5] && s[4]) || (s[3] && s[2]) || (s[1] && s[0]);
  endfunction

  function automatic logic [5:0] legal_rand();
    logic [5:0] s;
    s = 6'($urandom);
    if (s[5] && s[4]) s[4] = 1'b0;
    if (s[3] && s[2]) s[2] = 1'b0;
    if (s[1] && s[0]) s[0] = 1'b0;
    return s;
  endfunction

  task automatic model_edge();
    exp_t e;
    bit   live;
    if (!rst_n) begin
      m_active = 0; m_faulted = 0; m_phase = 0; m_dead_left = 0;
      m_pat = '0; m_per = 0; m_duty = 0;
    end else if (!ena) begin
      m_active = 0; m_faulted = 0; m_phase = 0;
    end else if (!m_active) begin
      m_active = 1; m_per = int'(period); m_duty = int'(duty);
      m_pat = status; m_phase = 0; m_dead_left = 0;
    end else if (m_faulted) begin
      m_phase = 0;
    end else if (is_illegal(status)) begin
      m_faulted = 1; m_phase = 0;
    end else begin
      if (m_phase == m_per) begin
        m_phase = 0; m_per = int'(period); m_duty = int'(duty);
      end else begin
        m_phase++;
      end
      if (m_dead_left > 0) begin
        m_dead_left--;
        if (m_dead_left == 0) m_pat = status;
      end else if (status != m_pat) begin
        if (dt == 0) m_pat = status;
        else m_dead_left = int'(dt);
      end
    end
    live = m_active && !m_faulted;
    e.f  = m_faulted;
    e.s  = live && (m_phase == 0);
    if (live && m_dead_left == 0)
      e.g = (m_phase < m_duty) ? m_pat : (m_pat & 6'b010101);
    else
      e.g = '0;
    exp_q.push_back(e);
  endtask

  // Called at a negedge; runs n clock edges and returns at a negedge.
  task automatic cyc(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
    end
  endtask

  task automatic chk(string name, logic [5:0] act, logic [5:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, req);
    end
  endtask

  // Monitor: the outputs are registered, so every cycle presents a response.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("gate_o", gate_o, e.g);
      chk("pwm_sync_o", {5'b0, pwm_sync_o}, {5'b0, e.s});
      chk("fault_o", {5'b0, fault_o}, {5'b0, e.f});
    end
  end

  initial begin
    rst_n = 1'b0; ena = 1'b1; status = 6'b100100;
    period = 10'd9; duty = 10'd5; dt = 6'd4;
    @(negedge clk);
    cyc(3);                                   // reset held with ena=1
    rst_n = 1'b1;
    cyc(25);                                  // 5 on / 5 off PWM

    status = 6'b100001; cyc(10);              // dead time of 4
    dt = 6'd0; status = 6'b100100; cyc(6);    // direct switch

    dt = 6'd6; status = 6'b100001; cyc(2);    // re-request inside dead time
    status = 6'b001001; cyc(12);

    duty = 10'd0;  cyc(22);                   // 0 % duty
    duty = 10'd15; cyc(22);                   // duty above period: 100 %
    duty = 10'd3;  cyc(14);
    cyc(2); duty = 10'd8; cyc(14);            // mid-period duty change

    status = 6'b110000; cyc(1);               // shoot-through
    status = 6'b001001; cyc(6);               // fault is sticky
    ena = 1'b0; cyc(2);
    ena = 1'b1; cyc(12);

    for (int i = 0; i < 2500; i++) begin
      int r;
      r   = $urandom_range(0, 999);
      ena = 1'b1;
      if (r < 6) begin
        ena = 1'b0;
        status = legal_rand();
      end else if (r < 11) begin
        status = legal_rand();
        case ($urandom_range(0, 2))
          0:       status[5:4] = 2'b11;
          1:       status[3:2] = 2'b11;
          default: status[1:0] = 2'b11;
        endcase
      end else if (r < 140 || is_illegal(status)) begin
        status = legal_rand();
      end
      if ($urandom_range(0, 19) == 0) begin
        period = 10'($urandom_range(2, 15));
        duty   = 10'($urandom_range(0, 18));
      end
      if ($urandom_range(0, 29) == 0) dt = 6'($urandom_range(0, 5));
      cyc(1);
    end

    // Async reset while the bridge is driven hard on.
    ena = 1'b1; status = 6'b100100; period = 10'd9; duty = 10'd15; dt = 6'd0;
    cyc(15);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_gate", gate_o, 6'b000000);
    chk("async_reset_fault", {5'b0, fault_o}, 6'b000000);
    @(negedge clk);
    cyc(2);
    rst_n = 1'b1;
    cyc(12);

    @(posedge clk); #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
